// File: rtl/tm1638_frame_ctrl.sv
// TM1638 refresh sequencer: data command, address plus 16 data bytes,
// then display control, bit-banged from a system-clock bit-rate counter.
module tm1638_frame_ctrl #(
    parameter int HALF_BIT = 50
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] seg_data,
    input  logic [2:0]   bright,
    input  logic         disp_on,
    output logic         busy,
    output logic         done,
    output logic         tm_stb,
    output logic         tm_clk,
    output logic         tm_dio
);

    localparam int CW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        F1,
        F2,
        F3
    } state_t;

    typedef enum logic [1:0] {
        SETUP,
        LOW,
        HIGH,
        GAP
    } phase_t;

    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [4:0]    byte_idx, byte_n;

    logic [127:0]  seg_q;
    logic [7:0]    ctl_q;

    logic          cnt_end;
    logic [4:0]    last_byte;
    logic [3:0]    seg_k;
    logic [7:0]    byte_sel;
    logic          stb_n;
    logic          clk_n;
    logic          dio_n;
    logic          busy_n;
    logic          done_n;

    assign cnt_end   = (cnt == CNT_MAX);
    assign last_byte = (state == F2) ? 5'd16 : 5'd0;

    // State, counters and pin registers; pins are registered from the
    // next-state decode so they change exactly with the state and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= SETUP;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tm_stb   <= 1'b1;
            tm_clk   <= 1'b1;
            tm_dio   <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            tm_stb   <= stb_n;
            tm_clk   <= clk_n;
            tm_dio   <= dio_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Snapshot the display image and control byte when a refresh is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            seg_q <= seg_data;
            ctl_q <= disp_on ? {5'b10001, bright} : 8'h80;
        end
    end

    // Next-state: half-bit counter drives phase, bit, byte and frame advance.
    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = byte_idx;
        if (state == IDLE) begin
            if (start) begin
                state_n = F1;
                phase_n = SETUP;
                cnt_n   = '0;
                bit_n   = '0;
                byte_n  = '0;
            end
        end else if (!cnt_end) begin
            cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
            unique case (phase)
                SETUP: phase_n = LOW;
                LOW:   phase_n = HIGH;
                HIGH: begin
                    phase_n = LOW;
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        if (byte_idx == last_byte) begin
                            phase_n = GAP;
                        end else begin
                            byte_n = byte_idx + 5'd1;
                        end
                    end
                end
                GAP: begin
                    phase_n = SETUP;
                    byte_n  = '0;
                    unique case (state)
                        F1:      state_n = F2;
                        F2:      state_n = F3;
                        default: state_n = IDLE;
                    endcase
                end
            endcase
        end
    end

    // Byte index 0 of F2 is the address command; 1..16 map to RAM 0..15.
    assign seg_k = byte_n[3:0] - 4'd1;

    // Output decode from the next state so the pin registers line up with it.
    always_comb begin
        unique case (state_n)
            F1:      byte_sel = 8'h40;
            F2: begin
                if (byte_n == 5'd0) begin
                    byte_sel = 8'hC0;
                end else begin
                    byte_sel = seg_q[{seg_k, 3'b000} +: 8];
                end
            end
            F3:      byte_sel = ctl_q;
            default: byte_sel = 8'hFF;
        endcase
        stb_n  = !(state_n != IDLE && phase_n != GAP);
        clk_n  = !(state_n != IDLE && phase_n == LOW);
        dio_n  = 1'b1;
        if (state_n != IDLE && (phase_n == LOW || phase_n == HIGH)) begin
            dio_n = byte_sel[bit_n];
        end
        busy_n = (state_n != IDLE);
        done_n = (state == F3) && (state_n == IDLE);
    end

endmodule

// File: tb/tb_tm1638_frame_ctrl.sv
// Scoreboard bench for tm1638_frame_ctrl: expected byte streams are queued
// at each start, a pin-level monitor decodes DIO frames and compares.
module tb_tm1638_frame_ctrl;

    localparam int H = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] seg_data;
    logic [2:0]   bright;
    logic         disp_on;
    logic         busy;
    logic         done;
    logic         tm_stb;
    logic         tm_clk;
    logic         tm_dio;

    tm1638_frame_ctrl #(.HALF_BIT(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seg_data (seg_data),
        .bright   (bright),
        .disp_on  (disp_on),
        .busy     (busy),
        .done     (done),
        .tm_stb   (tm_stb),
        .tm_clk   (tm_clk),
        .tm_dio   (tm_dio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_done = 0;
    int n_done = 0;

    logic [7:0] exp_bytes[$];
    int         exp_lens[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: what a refresh must put on the wire, frame by frame.
    task automatic push_model(input logic [127:0] s, input logic [2:0] b,
                              input logic on);
        int ctl;
        exp_bytes.push_back(8'h40);
        exp_lens.push_back(1);
        exp_bytes.push_back(8'hC0);
        for (int k = 0; k < 16; k++) exp_bytes.push_back(s[8*k +: 8]);
        exp_lens.push_back(17);
        ctl = on ? (128 + 8 + int'(b)) : 128;
        exp_bytes.push_back(8'(ctl));
        exp_lens.push_back(1);
        exp_done++;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        seg_data = rand128();
        bright   = 3'($urandom);
        disp_on  = 1'($urandom);
    endtask

    task automatic launch(input logic [127:0] s, input logic [2:0] b,
                          input logic on);
        seg_data = s;
        bright   = b;
        disp_on  = on;
        push_model(s, b, on);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            scramble();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Monitor state
    bit         p_stb = 1'b1;
    bit         p_clk = 1'b1;
    bit         p_dio = 1'b1;
    bit         p_busy = 1'b0;
    int         nbits = 0;
    int         nbytes = 0;
    int         win = 0;
    int         busy_cnt = 0;
    logic [7:0] shreg = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_bytes.delete();
            exp_lens.delete();
            nbits    = 0;
            nbytes   = 0;
            win      = 0;
            busy_cnt = 0;
            p_stb    = 1'b1;
            p_clk    = 1'b1;
            p_dio    = 1'b1;
            p_busy   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            chk("done_on_busy_fall", 32'(done), 32'(p_busy && !busy));
            if (p_busy && !busy) begin
                chk("busy_length", 32'(busy_cnt), 32'(310 * H));
                busy_cnt = 0;
            end
            if (done) n_done++;
            if (!tm_stb) begin
                if (p_stb) begin
                    win    = 0;
                    nbits  = 0;
                    nbytes = 0;
                end
                win++;
                if (!p_stb && p_clk && tm_clk) begin
                    chk("dio_stable_clk_high", 32'(tm_dio), 32'(p_dio));
                end
                if (!p_clk && tm_clk) begin
                    shreg = {tm_dio, shreg[7:1]};
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        nbytes++;
                        if (exp_bytes.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL byte: got %0h expected none",
                                     shreg);
                        end else begin
                            chk("byte", 32'(shreg),
                                32'(exp_bytes.pop_front()));
                        end
                    end
                end
            end else if (!p_stb) begin
                if (exp_lens.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame: got %0d bytes expected none",
                             nbytes);
                end else begin
                    int len;
                    len = exp_lens.pop_front();
                    chk("frame_bytes", 32'(nbytes), 32'(len));
                    chk("frame_partial_bits", 32'(nbits), 32'd0);
                    chk("stb_low_cycles", 32'(win), 32'((1 + 16 * len) * H));
                end
            end
            p_stb  = tm_stb;
            p_clk  = tm_clk;
            p_dio  = tm_dio;
            p_busy = busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s;
        int           bcnt;

        rst      = 1'b1;
        start    = 1'b1;
        seg_data = '0;
        bright   = '0;
        disp_on  = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_stb", 32'(tm_stb), 32'd1);
            chk("rst_clk", 32'(tm_clk), 32'd1);
            chk("rst_dio", 32'(tm_dio), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        idle(3);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 16; k++) s[8*k +: 8] = 8'(k * 17);
        launch(s, 3'd7, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("stb_after_start", 32'(tm_stb), 32'd0);
        wait_done(700);
        idle(3);

        launch(rand128(), 3'd5, 1'b1);
        wait_done(700);
        idle(2);
        launch(rand128(), 3'd5, 1'b0);
        wait_done(700);
        idle(2);

        launch(rand128(), 3'($urandom), 1'b1);
        for (int i = 0; i < 100; i++) begin
            tick();
            scramble();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(700);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) bcnt++;
        end
        chk("no_queued_start", 32'(bcnt), 32'd0);

        launch(rand128(), 3'($urandom), 1'($urandom));
        wait_done(700);
        launch(rand128(), 3'($urandom), 1'($urandom));
        wait_done(700);
        idle(3);

        launch(rand128(), 3'd3, 1'b1);
        exp_done--;
        idle(204);
        rst = 1'b1;
        tick();
        chk("midrst_stb", 32'(tm_stb), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_clk", 32'(tm_clk), 32'd1);
        tick();
        rst = 1'b0;
        idle(3);
        launch(rand128(), 3'd2, 1'b1);
        wait_done(700);
        idle(2);

        repeat (4) begin
            launch(rand128(), 3'($urandom), 1'($urandom));
            wait_done(700);
            idle(int'($urandom_range(0, 5)));
        end

        idle(10);
        chk("done_count", 32'(n_done), 32'(exp_done));
        chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
        chk("frames_left", 32'(exp_lens.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
